// File: rtl/ncu_mcu_pkg.sv
// Shared definitions for the NCU->MCU downstream serial request path.
// Holds the packet geometry and the receive assembly FSM state type.
package ncu_mcu_pkg;

  localparam int unsigned NCU_MCU_PKT_W   = 128;
  localparam int unsigned NCU_MCU_NIB_W   = 4;
  localparam int unsigned NCU_MCU_NIBBLES = NCU_MCU_PKT_W / NCU_MCU_NIB_W;
  localparam int unsigned NCU_MCU_CNT_W   = $clog2(NCU_MCU_NIBBLES);

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ASM  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/ncu_mcu_rx_fifo.sv
// Small pointer-based packet FIFO.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   wr, wdata   - push request and data (ignored when full unless a pop frees a slot)
//   rd          - pop request, honoured only when vld is high
//   rdata, vld  - head entry (forced to zero when empty) and head valid
//   count       - current number of stored entries
module ncu_mcu_rx_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         rd,
  output logic [WIDTH-1:0]             rdata,
  output logic                         vld,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             rd_fire, wr_fire;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign vld     = (count_q != '0);
  assign rd_fire = rd & vld;
  assign wr_fire = wr & ((count_q != CntW'(DEPTH)) | rd_fire);
  // Zero when empty so the head reads as zero out of reset.
  assign rdata   = vld ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ncu_mcu_dn_rx.sv
// MCU-side receiver for the NCU->MCU 4-bit serial request interface.
// Deserialises 32-nibble packets (LS nibble first) into 128-bit words and
// queues them for the MCU CSR logic, with registered back-pressure.
// Ports:
//   iol2clk, rst_l             - clock and asynchronous active-low reset
//   ncu_mcu_vld, ncu_mcu_data  - start-of-packet strobe and serial nibble
//   mcu_ncu_stall              - back-pressure to the NCU
//   rx_pkt_vld/data/rdy        - FIFO head handshake toward the consumer
//   rx_proto_err, rx_err_clr   - sticky protocol error flag and its clear
module ncu_mcu_dn_rx
  import ncu_mcu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     iol2clk,
  input  logic                     rst_l,
  input  logic                     ncu_mcu_vld,
  input  logic [NCU_MCU_NIB_W-1:0] ncu_mcu_data,
  output logic                     mcu_ncu_stall,
  output logic                     rx_pkt_vld,
  output logic [NCU_MCU_PKT_W-1:0] rx_pkt_data,
  input  logic                     rx_pkt_rdy,
  output logic                     rx_proto_err,
  input  logic                     rx_err_clr
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  rx_state_e                state_q, state_d;
  logic [NCU_MCU_CNT_W-1:0] nib_q, nib_d;
  logic [NCU_MCU_PKT_W-1:0] asm_q, asm_d, asm_shift;
  logic                     stall_q, stall_d;
  logic                     err_q, err_d;
  logic                     push, push_ok, pop, full, err_set;
  logic [CntW-1:0]          fifo_cnt, cnt_next;
  logic [CntW:0]            occ_next;

  // Nibbles enter at the top and shift down; after 32 captures nibble 0 sits in [3:0].
  assign asm_shift = {ncu_mcu_data, asm_q[NCU_MCU_PKT_W-1:NCU_MCU_NIB_W]};

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    asm_d   = asm_q;
    push    = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (ncu_mcu_vld) begin
          if (stall_q) begin
            // NCU ignored back-pressure: drop the whole packet.
            err_set = 1'b1;
          end else begin
            asm_d   = asm_shift;
            nib_d   = '0;
            state_d = RX_ASM;
          end
        end
      end
      RX_ASM: begin
        asm_d = asm_shift;
        if (ncu_mcu_vld) begin
          // Early start: abandon the partial packet, this nibble restarts assembly.
          err_set = 1'b1;
          nib_d   = '0;
        end else begin
          nib_d = nib_q + NCU_MCU_CNT_W'(1);
          if (nib_q == NCU_MCU_CNT_W'(NCU_MCU_NIBBLES - 2)) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    pop      = rx_pkt_vld & rx_pkt_rdy;
    full     = (fifo_cnt == CntW'(DEPTH));
    push_ok  = push & (~full | pop);
    cnt_next = fifo_cnt;
    if (push_ok && !pop) begin
      cnt_next = fifo_cnt + CntW'(1);
    end else if (!push_ok && pop) begin
      cnt_next = fifo_cnt - CntW'(1);
    end
    // A packet in assembly already owns a slot.
    occ_next = {1'b0, cnt_next} + {{CntW{1'b0}}, (state_d == RX_ASM)};
    stall_d  = (occ_next >= (CntW + 1)'(DEPTH));
    err_d    = rx_err_clr ? 1'b0 : err_q;
    if (err_set || (push && !push_ok)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= RX_IDLE;
      nib_q   <= '0;
      asm_q   <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      asm_q   <= asm_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  ncu_mcu_rx_fifo #(
    .WIDTH (NCU_MCU_PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (iol2clk),
    .rst_n (rst_l),
    .wr    (push_ok),
    .wdata (asm_shift),
    .rd    (pop),
    .rdata (rx_pkt_data),
    .vld   (rx_pkt_vld),
    .count (fifo_cnt)
  );

  assign mcu_ncu_stall = stall_q;
  assign rx_proto_err  = err_q;

endmodule

// File: doc/ncu_mcu_dn_rx.md
# ncu_mcu_dn_rx

MCU-side receiver for the NCU→MCU downstream 4-bit serial request interface (ncu_mcuN_vld / ncu_mcuN_data / mcuN_ncu_stall). It deserializes 32-nibble packets into 128-bit words and buffers them in a small FIFO toward the MCU register/CSR logic. Buffer occupancy drives `mcu_ncu_stall` back to the NCU. One instance is placed per MCU (0–3), at the MCU boundary.

## Interface
- DEPTH, 2: packet FIFO entries. Must be ≥2.
- iol2clk  in  1  interface clock; all logic is on the rising edge.
- rst_l  in  1  asynchronous reset, active-low.
- ncu_mcu_vld  in  1  one-cycle start-of-packet strobe; accompanies nibble 0.
- ncu_mcu_data  in  4  serial packet nibble.
- mcu_ncu_stall  out  1  registered back-pressure to the NCU.
- rx_pkt_vld  out  1  FIFO head valid.
- rx_pkt_data  out  128  FIFO head packet.
- rx_pkt_rdy  in  1  consumer accepts the head packet when this is high and rx_pkt_vld is high.
- rx_proto_err  out  1  sticky protocol-error flag.
- rx_err_clr  in  1  clears rx_proto_err; set has priority.

## Operation
- Packet format: 128 bits carried as 32 nibbles, least-significant first. Nibble i maps to bits [4i+3:4i]. Nibble 0 arrives in the vld cycle; nibbles 1–31 arrive in the following 31 consecutive cycles, with vld low.
- Assembly FSM:
  - IDLE: vld=1 → capture nibble 0, clear the 5-bit counter, go to ASM.
  - ASM: capture a nibble and increment the counter each cycle. When nibble 31 is captured, push the assembled word to the FIFO and return to IDLE.
- Accept rule: a vld seen while mcu_ncu_stall=1 is a protocol error. The packet is ignored (state stays IDLE) and rx_proto_err is set.
- vld=1 while in ASM is a protocol error:
  - the partial packet is discarded;
  - rx_proto_err is set;
  - the current cycle is treated as nibble 0 of a new packet.
- Stall: next_stall = (next_count + next_in_asm) ≥ DEPTH, where next_in_asm is 1 if the FSM will be in ASM next cycle.
- FIFO: write when the last nibble is captured; read on rx_pkt_vld & rx_pkt_rdy. A simultaneous push and pop leaves count unchanged.
- Overflow is impossible when the stall rule is honoured. If it is reached anyway, the push is dropped and rx_proto_err is set.
- Reset values: FSM=IDLE, count=0, mcu_ncu_stall=0, rx_pkt_vld=0, rx_pkt_data=0, rx_proto_err=0.
- Reset asserted mid-packet discards the partial packet and all FIFO contents.

## Timing
- Latency: nibble 31 is sampled at edge k, and rx_pkt_vld=1 with the complete data is visible after edge k.
- mcu_ncu_stall is updated at the same edge as the state change that causes it; there is no extra pipeline stage.
  - With DEPTH=2, count=1, and a new packet started at edge s: stall=1 after edge s.
  - The NCU samples stall before driving vld. Back-to-back packets (vld on cycle s+32) are legal only if stall was 0 at that edge.
- A pop at edge p with count=DEPTH drops stall after edge p (combined next_count rule).
- rx_pkt_data holds stable while rx_pkt_vld=1 and rx_pkt_rdy=0.

## Structure
- Shared package `ncu_mcu_pkg`:
  - NCU_MCU_PKT_W=128, NCU_MCU_NIB_W=4, NCU_MCU_NIBBLES=32;
  - FSM state enum {RX_IDLE, RX_ASM}.
- Sub-module `ncu_mcu_rx_fifo`:
  - parameterised width/depth, pointer-based, exposes count;
  - instantiated once.
- Top level holds the FSM, the shift/assembly register, stall and error logic.

## Test plan
- Single packet, nibbles 0x0..0xF,0x0..0xF (nibble i = i mod 16): rx_pkt_data=128'hFEDCBA9876543210FEDCBA9876543210, rx_pkt_vld high one cycle after nibble 31, stall stays 0.
- DEPTH=2, rdy=0, two back-to-back packets A then B: stall=1 from the start of B onward; both held in order; rdy=1 pops A then B; stall drops after the first pop.
- vld asserted at nibble 10 of packet A, followed by a full packet B: rx_proto_err=1, only B appears in the FIFO.
- vld while stall=1: packet ignored, err=1, FIFO count unchanged; rx_err_clr clears err the next cycle.
- Simultaneous push and pop with count=1: count stays 1, stall stays consistent with the rule, no data corruption.
- rst_l asserted at nibble 20 with one packet queued: all outputs return to reset values immediately; a following packet is received correctly.
